jt49_dcrm: RTL and testbench
============================

JT49_DCRM -- requirements
Module: jt49_dcrm

Interface
REQ-001 SHALL have parameter DW, default 10; sound input width, matching the 10-bit PSG mixer output.
REQ-002 SHALL have parameter LOG2N, default 4; log2 of the averaging window length N = 2^LOG2N samples.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cen  input  1  sample strobe; one input sample is consumed per cycle with cen=1.
REQ-006 SHALL have port clr  input  1  synchronous filter restart, sampled every cycle regardless of cen.
REQ-007 SHALL have port din  input  DW  unsigned sound sample from the PSG mixer.
REQ-008 SHALL have port dout  output  DW+1  signed two's-complement sample with DC removed.
REQ-009 SHALL have port settled  output  1  high once the averaging window holds N real samples.

Function
REQ-010 SHALL keep a ring buffer B[0..N-1] of DW-bit entries, a write pointer P (LOG2N bits), a running sum S (DW+LOG2N bits) and a fill counter C (LOG2N bits).
REQ-011 SHALL use two states: FILL (fewer than N samples absorbed) and RUN (window full).
REQ-012 On a cycle with cen=1 and clr=0, SHALL update dout <= {1'b0,din} - (S >> LOG2N), with S taken before the update of REQ-013.
REQ-013 On the same cycle, SHALL update S <= S + din - B[P], B[P] <= din and P <= P+1, with P wrapping from N-1 to 0.
REQ-014 In FILL with cen=1, SHALL increment C; when C=N-1, SHALL enter RUN and set settled=1 in the same edge.
REQ-015 In RUN, SHALL leave C unchanged and keep settled=1.
REQ-016 SHALL give dout a latency of exactly one clk edge after the qualifying cen cycle, and SHALL hold dout between strobes.
REQ-017 SHALL never overflow S: the maximum value N*(2^DW-1) fits in DW+LOG2N bits.
REQ-018 SHALL keep dout within the range -(2^DW-1)..+(2^DW-1) with no wrap.
REQ-019 On a cycle with cen=0, SHALL keep all state and outputs unchanged, except for the action of clr.
REQ-020 SHALL give clr=1 priority over cen=1: the sample on that cycle is discarded and the block performs the reset actions of REQ-022.
REQ-021 SHALL update dout only on cen cycles; its value at the FILL-to-RUN edge follows REQ-012 with no special case.

Reset
REQ-022 On rst=1, SHALL set all B entries, S, P and C to 0, dout to 0, settled to 0, and the state to FILL.
REQ-023 On rst=1 mid-operation, SHALL discard any in-flight sample; the first cen after rst deasserts is treated as sample 1.

Configuration
REQ-024 SHALL support the macro JT49_DCRM_SEED_EN.
REQ-025 With JT49_DCRM_SEED_EN defined, the first cen in FILL SHALL write din into every B entry, set S <= din << LOG2N, P <= 1, dout <= 0, settled <= 1 and state RUN. This removes the start-up thump.
REQ-026 Without JT49_DCRM_SEED_EN, FILL SHALL behave exactly as REQ-012 to REQ-014, and settled SHALL rise after N strobes.

Structure
REQ-027 The shared package jt49_pkg SHALL hold the default DW and LOG2N values and the FILL/RUN state encoding.
REQ-028 The ring buffer SHALL be a sub-module, jt49_dcrm_buf, with one read port and one write port at the same address P. It SHALL also provide a broadcast-write input used only when JT49_DCRM_SEED_EN is defined.
REQ-029 The state machine, S, C and the output arithmetic SHALL live in jt49_dcrm.

Verification
REQ-030 No seed: rst, then din=512 on every cen -> dout=512 after cen 1, 480 after cen 2, 0 after cen 17 and thereafter; settled rises at cen 16.
REQ-031 Seed (JT49_DCRM_SEED_EN): rst, then din=512 -> dout=0 from cen 1 onward; settled=1 after cen 1.
REQ-032 Step: after settling on din=0, switch to din=1023 -> dout=1023, 960, 896, ... decaying to 0 at step sample 17. Then drop to din=0 -> dout=-1023.
REQ-033 Wrap and gaps: 40 cen strobes separated by random idle cycles -> P wraps 15->0 twice, and dout and S are unchanged during idle cycles.
REQ-034 clr together with cen=1 and din=700 after settling -> sample discarded, S=0, settled=0, dout=0, and the next cen with din=700 gives dout=700.
REQ-035 rst asserted at cen 9 of FILL -> all state is cleared, and the following sequence reproduces REQ-030 exactly.

Source files
------------

// File: rtl/jt49_pkg.sv
// ============================================================================
//  Module      : jt49_pkg
//  Description : Shared constants for the JT49 DC-removal filter: default
//                sample width, default averaging window and state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jt49_pkg;

  // Default sound width, matching the 10-bit PSG mixer output
  localparam int c_DCRM_DW    = 10;
  // Default log2 of the averaging window length
  localparam int c_DCRM_LOG2N = 4;

  // Filter state encoding
  localparam logic [0:0] c_ST_FILL = 1'b0;  // window not yet full
  localparam logic [0:0] c_ST_RUN  = 1'b1;  // window full, output settled

endpackage

`default_nettype wire

// File: rtl/jt49_dcrm_if.sv
// ============================================================================
//  Module      : jt49_dcrm_if
//  Description : Sample-stream interface of the DC-removal filter. The master
//                drives the strobe, restart and sample; the slave returns the
//                DC-free sample and the settled flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface jt49_dcrm_if #(
  parameter int DW = 10
);
  logic                cen;
  logic                clr;
  logic [DW-1:0]       din;
  logic signed [DW:0]  dout;
  logic                settled;

  modport master (output cen, output clr, output din, input dout, input settled);
  modport slave  (input cen, input clr, input din, output dout, output settled);
endinterface

`default_nettype wire

// File: rtl/jt49_dcrm_buf.sv
// ============================================================================
//  Module      : jt49_dcrm_buf
//  Description : Ring buffer of the averaging window. One asynchronous read
//                port and one write port share the same address, so the
//                sample leaving the window is visible in the cycle it is
//                overwritten. A broadcast write loads every entry at once.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jt49_dcrm_buf #(
  parameter int DW    = 10,
  parameter int LOG2N = 4
) (
  input  wire logic             clk,
  input  wire logic             clr,
  input  wire logic             we,
  input  wire logic             bcast_we,
  input  wire logic [LOG2N-1:0] addr,
  input  wire logic [DW-1:0]    wdata,
  output logic [DW-1:0]         rdata
);

  localparam int c_N = 1 << LOG2N;

  logic [DW-1:0] r_mem [c_N];

  // Oldest sample in the window, read before this cycle's write lands
  assign rdata = r_mem[addr];

  // Clear has priority over broadcast, broadcast over the single write
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < c_N; i++) r_mem[i] <= '0;
    end else if (bcast_we) begin
      for (int i = 0; i < c_N; i++) r_mem[i] <= wdata;
    end else if (we) begin
      r_mem[addr] <= wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/jt49_dcrm.sv
// ============================================================================
//  Module      : jt49_dcrm
//  Description : DC-removal filter for the JT49 PSG. Subtracts the moving
//                average of the last 2^LOG2N samples from each new sample.
//                Optional macro JT49_DCRM_SEED_EN: the first strobe after a
//                restart fills the whole window with that sample, so the
//                output starts at zero instead of with a start-up thump.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jt49_dcrm
  import jt49_pkg::*;
#(
  parameter int DW    = c_DCRM_DW,
  parameter int LOG2N = c_DCRM_LOG2N
) (
  input  wire logic   clk,
  input  wire logic   rst,
  jt49_dcrm_if.slave  bus
);

  localparam int c_N  = 1 << LOG2N;
  localparam int c_SW = DW + LOG2N;   // holds N*(2^DW-1) without overflow

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [c_SW-1:0]    r_sum;
  logic [LOG2N-1:0]   r_ptr;
  logic [LOG2N-1:0]   r_cnt;
  logic signed [DW:0] r_dout;

  logic               w_restart;
  logic               w_acc;
  logic               w_seed;
  logic               w_cnt_inc;
  logic [DW-1:0]      w_old;
  logic signed [DW:0] w_din_s;
  logic signed [DW:0] w_mean_s;

  // clr behaves like reset and wins over a concurrent strobe
  assign w_restart = rst | bus.clr;

  // Both operands are non-negative and fit DW bits, so DW+1 signed never wraps
  assign w_din_s  = signed'({1'b0, bus.din});
  assign w_mean_s = signed'({1'b0, r_sum[c_SW-1:LOG2N]});

  jt49_dcrm_buf #(
    .DW    (DW),
    .LOG2N (LOG2N)
  ) u_buf (
    .clk      (clk),
    .clr      (w_restart),
    .we       (w_acc),
    .bcast_we (w_seed),
    .addr     (r_ptr),
    .wdata    (bus.din),
    .rdata    (w_old)
  );

  // State register
  always_ff @(posedge clk) begin
    if (w_restart) r_state <= c_ST_FILL;
    else           r_state <= w_state_nxt;
  end

  // Next state: leave FILL once the window is full (or immediately when seeding)
  always_comb begin
    w_state_nxt = r_state;
    if (bus.cen && r_state == c_ST_FILL) begin
`ifdef JT49_DCRM_SEED_EN
      w_state_nxt = c_ST_RUN;
`else
      if (r_cnt == LOG2N'(c_N - 1)) w_state_nxt = c_ST_RUN;
`endif
    end
  end

  // Per-state datapath controls for a qualifying strobe
  always_comb begin
    w_acc     = 1'b0;
    w_seed    = 1'b0;
    w_cnt_inc = 1'b0;
    if (bus.cen && !w_restart) begin
      if (r_state == c_ST_FILL) begin
`ifdef JT49_DCRM_SEED_EN
        w_seed    = 1'b1;
`else
        w_acc     = 1'b1;
        w_cnt_inc = 1'b1;
`endif
      end else begin
        w_acc = 1'b1;
      end
    end
  end

  // Running sum, pointer, fill counter and output sample
  always_ff @(posedge clk) begin
    if (w_restart) begin
      r_sum  <= '0;
      r_ptr  <= '0;
      r_cnt  <= '0;
      r_dout <= '0;
    end else begin
      if (w_seed) begin
        r_sum  <= c_SW'(bus.din) << LOG2N;
        r_ptr  <= LOG2N'(1);
        r_dout <= '0;
      end else if (w_acc) begin
        r_sum  <= r_sum + c_SW'(bus.din) - c_SW'(w_old);
        r_ptr  <= r_ptr + LOG2N'(1);
        r_dout <= w_din_s - w_mean_s;
      end
      if (w_cnt_inc) r_cnt <= r_cnt + LOG2N'(1);
    end
  end

  assign bus.dout    = r_dout;
  assign bus.settled = (r_state == c_ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_jt49_dcrm.sv
// ============================================================================
//  Module      : tb_jt49_dcrm
//  Description : Self-checking bench for jt49_dcrm. A window-average model
//                predicts dout/settled for every cycle; a monitor compares
//                the DUT against the predictions one edge later.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jt49_dcrm;
  import jt49_pkg::*;

  localparam int DW    = c_DCRM_DW;
  localparam int LOG2N = c_DCRM_LOG2N;
  localparam int N     = 1 << LOG2N;

  logic clk = 1'b0;
  logic rst = 1'b1;

  jt49_dcrm_if #(.DW(DW)) bus ();

  jt49_dcrm #(.DW(DW), .LOG2N(LOG2N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dout;
    bit settled;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: the window is the list of the last N absorbed samples
  int hist[$];
  int nsamp  = 0;
  int m_dout = 0;
  bit m_set  = 1'b0;

  function automatic void model(input bit r, input bit c, input bit cl, input int d);
    int sum;
    if (r || cl) begin
      hist.delete();
      nsamp  = 0;
      m_dout = 0;
      m_set  = 1'b0;
    end else if (c) begin
`ifdef JT49_DCRM_SEED_EN
      if (nsamp == 0) begin
        for (int i = 0; i < N; i++) hist.push_back(d);
        nsamp  = N;
        m_dout = 0;
        m_set  = 1'b1;
        return;
      end
`endif
      sum = 0;
      foreach (hist[i]) sum += hist[i];
      m_dout = d - (sum / N);
      hist.push_back(d);
      if (hist.size() > N) void'(hist.pop_front());
      nsamp++;
      m_set = (nsamp >= N);
    end
  endfunction

  function automatic void check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // One cycle of stimulus; the prediction for the following edge is queued
  task automatic step(input bit r, input bit c, input bit cl, input int d);
    exp_t e;
    @(negedge clk);
    rst     = r;
    bus.cen = c;
    bus.clr = cl;
    bus.din = DW'(d);
    model(r, c, cl, d);
    e.dout    = m_dout;
    e.settled = m_set;
    sb.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: compare the DUT against the oldest queued prediction
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("dout", int'(bus.dout), e.dout);
      check("settled", int'(bus.settled), int'(e.settled));
    end
  end

  initial begin
    bus.cen = 1'b0;
    bus.clr = 1'b0;
    bus.din = '0;

    // Reset state
    step(1, 0, 0, 0);
    step(1, 1, 0, 300);

    // Constant 512 from reset, with literal spot checks
    for (int k = 1; k <= 20; k++) begin
      step(0, 1, 0, 512);
      #2;
`ifndef JT49_DCRM_SEED_EN
      if (k == 1)  check("c030_cen1", int'(bus.dout), 512);
      if (k == 2)  check("c030_cen2", int'(bus.dout), 480);
      if (k == 15) check("c030_set15", int'(bus.settled), 0);
      if (k == 16) check("c030_set16", int'(bus.settled), 1);
      if (k == 17) check("c030_cen17", int'(bus.dout), 0);
`else
      if (k == 1) check("c031_cen1", int'(bus.dout), 0);
      if (k == 1) check("c031_set1", int'(bus.settled), 1);
`endif
    end

    // Reset in the middle of FILL, then the same sequence again
    step(1, 0, 0, 0);
    for (int k = 1; k <= 8; k++) step(0, 1, 0, 512);
    step(1, 1, 0, 512);
    for (int k = 1; k <= 20; k++) begin
      step(0, 1, 0, 512);
      #2;
`ifndef JT49_DCRM_SEED_EN
      if (k == 2)  check("c035_cen2", int'(bus.dout), 480);
      if (k == 17) check("c035_cen17", int'(bus.dout), 0);
`endif
    end

    // Step response: settle on 0, jump to full scale, drop back to 0
    step(1, 0, 0, 0);
    for (int k = 0; k < 20; k++) step(0, 1, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step(0, 1, 0, 1023);
      #2;
      if (k == 1)  check("c032_step1", int'(bus.dout), 1023);
      if (k == 2)  check("c032_step2", int'(bus.dout), 960);
      if (k == 17) check("c032_step17", int'(bus.dout), 0);
    end
    step(0, 1, 0, 0);
    #2;
    check("c032_drop", int'(bus.dout), -1023);

    // Wrap-around with random idle gaps; din wiggles while idle
    for (int k = 0; k < 40; k++) begin
      step(0, 1, 0, int'($urandom_range(1023)));
      repeat ($urandom_range(3)) step(0, 0, 0, int'($urandom_range(1023)));
    end

    // clr with a concurrent strobe discards the sample
    step(0, 1, 1, 700);
    step(0, 0, 0, 5);
    step(0, 1, 0, 700);
    #2;
    check("c034_after_clr", int'(bus.dout), 700);

    // Random traffic with occasional restarts
    for (int k = 0; k < 400; k++)
      step(($urandom_range(127) == 0), $urandom_range(1),
           ($urandom_range(63) == 0), int'($urandom_range(1023)));

    repeat (3) step(0, 0, 0, 0);
    @(negedge clk);
    check("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
